ahb_arbiter: RTL and testbench

Round-robin bus arbiter for the shared AHB bus, placed between N managers and the common address/data mux that drives `AHBCommon_if` subordinates. It grants address-phase ownership to one manager at a time and tracks the data-phase owner so the read-data/response mux stays aligned. Grant changes only at legal transfer boundaries, so locked sequences, bursts, wait states and two-cycle ERROR responses are preserved. When nobody requests, the bus parks on a default manager.

---
 rtl/ahb_arbiter_pkg.sv | 17 +
 rtl/ahb_rr_picker.sv | 30 +++
 rtl/ahb_arbiter.sv | 94 +++++++++
 tb/tb_ahb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings plus the arbiter state type.
package AHBCommon_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef logic [1:0] ArbState;
  localparam ArbState ARB_PARK   = 2'd0;
  localparam ArbState ARB_OWNED  = 2'd1;
  localparam ArbState ARB_LOCKED = 2'd2;

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin request picker: searches from last+1 upward, wrapping, with last itself checked at the end.
module ahb_rr_picker #(
  parameter int unsigned NumManagers = 4
) (
  input  logic [NumManagers-1:0]         req,
  input  logic [$clog2(NumManagers)-1:0] last,
  output logic [$clog2(NumManagers)-1:0] owner,
  output logic                           valid
);

  localparam int unsigned IdxW = $clog2(NumManagers);

  int unsigned idx;

  always_comb begin
    owner = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NumManagers; i++) begin
      // explicit wrap so non-power-of-two manager counts work
      idx = 32'(last) + i;
      if (idx >= NumManagers) idx = idx - NumManagers;
      if (!valid && req[IdxW'(idx)]) begin
        valid = 1'b1;
        owner = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: grants address-phase ownership at legal transfer boundaries
// and tracks the data-phase owner for the read-data/response mux.
module ahb_arbiter
  import AHBCommon_pkg::*;
#(
  parameter int unsigned NumManagers    = 4,
  parameter int unsigned DefaultManager = 0,
  parameter int unsigned HoldLimit      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NumManagers-1:0]         req,
  input  logic [NumManagers-1:0]         lock,
  input  logic [1:0]                     trans,
  input  logic                           ready,
  input  logic                           resp,
  output logic [NumManagers-1:0]         grant,
  output logic [$clog2(NumManagers)-1:0] addrOwner,
  output logic [$clog2(NumManagers)-1:0] dataOwner,
  output logic                           locked
);

  localparam int unsigned IdxW = $clog2(NumManagers);
  localparam int unsigned CntW = (HoldLimit > 0) ? $clog2(HoldLimit + 1) : 1;

  ArbState          state, state_nxt;
  logic [IdxW-1:0]  owner_nxt;
  logic [CntW-1:0]  hold_cnt, hold_cnt_nxt;
  logic [IdxW-1:0]  pick_owner;
  logic             pick_valid;
  logic             handover, switch_ok, others, hold_hit, rel, change;

  ahb_rr_picker #(.NumManagers(NumManagers)) u_picker (
    .req   (req),
    .last  (addrOwner),
    .owner (pick_owner),
    .valid (pick_valid)
  );

  // A first-cycle ERROR always has ready low, so it is covered by the ready qualifier.
  assign handover  = ready && !((resp == RESP_ERROR) && !ready);
  assign switch_ok = handover && ((trans == TRANS_IDLE) || (trans == TRANS_NONSEQ));
  assign others    = |(req & ~(NumManagers'(1) << addrOwner));
  assign hold_hit  = (HoldLimit != 0) && (hold_cnt >= CntW'(HoldLimit));

  always_comb begin
    state_nxt    = state;
    owner_nxt    = addrOwner;
    hold_cnt_nxt = hold_cnt;
    rel          = 1'b0;
    change       = 1'b0;
    case (state)
      ARB_PARK:   rel = |req;
      ARB_OWNED:  rel = !req[addrOwner] || (others && ((trans == TRANS_IDLE) || hold_hit));
      ARB_LOCKED: rel = !lock[addrOwner] && (trans == TRANS_IDLE);
      default:    rel = 1'b1;
    endcase
    if (switch_ok && rel) begin
      change = 1'b1;
      if (pick_valid) begin
        owner_nxt = pick_owner;
        state_nxt = lock[pick_owner] ? ARB_LOCKED : ARB_OWNED;
      end else begin
        owner_nxt = IdxW'(DefaultManager);
        state_nxt = ARB_PARK;
      end
    end
    // counts accepted transfers of the current tenure, saturating
    if (change) begin
      hold_cnt_nxt = '0;
    end else if (ready && trans[1] && (hold_cnt < CntW'(HoldLimit))) begin
      hold_cnt_nxt = hold_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_PARK;
      grant     <= NumManagers'(1) << DefaultManager;
      addrOwner <= IdxW'(DefaultManager);
      dataOwner <= IdxW'(DefaultManager);
      locked    <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= NumManagers'(1) << owner_nxt;
      addrOwner <= owner_nxt;
      locked    <= (state_nxt == ARB_LOCKED);
      hold_cnt  <= hold_cnt_nxt;
      if (ready) dataOwner <= addrOwner;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed table, corner-case sequences and random traffic vs a reference model.
module tb_ahb_arbiter;
  import AHBCommon_pkg::*;

  localparam int NM   = 4;
  localparam int DEF  = 0;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, lock;
  logic [1:0] trans;
  logic       ready, resp;
  logic [3:0] grant;
  logic [1:0] addrOwner, dataOwner;
  logic       locked;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: owner index, data owner, tenure transfer count, parked / locked flags
  int m_owner, m_data, m_cnt;
  bit m_park, m_lock;

  ahb_arbiter #(.NumManagers(NM), .DefaultManager(DEF), .HoldLimit(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .trans(trans),
    .ready(ready), .resp(resp), .grant(grant), .addrOwner(addrOwner),
    .dataOwner(dataOwner), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic       ready;
    logic       resp;
    logic [3:0] g;
    int         a;
    int         d;
    logic       l;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = DEF;
    m_data  = DEF;
    m_cnt   = 0;
    m_park  = 1'b1;
    m_lock  = 1'b0;
  endtask

  // one clock of the arbitration rules applied to the currently driven inputs
  task automatic model_step();
    bit others, rel, found;
    int win;
    others = 1'b0;
    for (int i = 0; i < NM; i++)
      if (i != m_owner && req[2'(i)]) others = 1'b1;
    if (m_park)      rel = (req != 4'b0);
    else if (m_lock) rel = !lock[2'(m_owner)] && (trans == TRANS_IDLE);
    else             rel = !req[2'(m_owner)] ||
                           (others && ((trans == TRANS_IDLE) || (HOLD > 0 && m_cnt >= HOLD)));
    if (ready) m_data = m_owner;
    if (ready && (trans == TRANS_IDLE || trans == TRANS_NONSEQ) && rel) begin
      found = 1'b0;
      win   = DEF;
      for (int k = 1; k <= NM; k++) begin
        if (!found && req[2'((m_owner + k) % NM)]) begin
          found = 1'b1;
          win   = (m_owner + k) % NM;
        end
      end
      m_owner = win;
      m_park  = !found;
      m_lock  = found && lock[2'(win)];
      m_cnt   = 0;
    end else if (ready && (trans == TRANS_NONSEQ || trans == TRANS_SEQ) && m_cnt < HOLD) begin
      m_cnt++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".grant"},     int'(grant),     int'(4'b0001 << m_owner));
    chk({tag, ".addrOwner"}, int'(addrOwner), m_owner);
    chk({tag, ".dataOwner"}, int'(dataOwner), m_data);
    chk({tag, ".locked"},    int'(locked),    int'(m_lock));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [1:0] t,
                       input logic rd, input logic rs, input string tag);
    req = r; lock = l; trans = t; ready = rd; resp = rs;
    cycle(tag);
  endtask

  initial begin
    tbl[0] = '{4'b1010, 4'b0000, TRANS_IDLE,   1'b1, RESP_OKAY, 4'b0010, 1, 0, 1'b0};
    tbl[1] = '{4'b1111, 4'b0000, TRANS_NONSEQ, 1'b1, RESP_OKAY, 4'b0010, 1, 1, 1'b0};
    tbl[2] = '{4'b1111, 4'b0000, TRANS_IDLE,   1'b1, RESP_OKAY, 4'b0100, 2, 1, 1'b0};
    tbl[3] = '{4'b1111, 4'b0000, TRANS_NONSEQ, 1'b1, RESP_OKAY, 4'b0100, 2, 2, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, TRANS_IDLE,   1'b1, RESP_OKAY, 4'b1000, 3, 2, 1'b0};
    tbl[5] = '{4'b1111, 4'b0000, TRANS_NONSEQ, 1'b1, RESP_OKAY, 4'b1000, 3, 3, 1'b0};
    tbl[6] = '{4'b1111, 4'b0000, TRANS_IDLE,   1'b1, RESP_OKAY, 4'b0001, 0, 3, 1'b0};
    tbl[7] = '{4'b1111, 4'b0000, TRANS_NONSEQ, 1'b1, RESP_OKAY, 4'b0001, 0, 0, 1'b0};
    tbl[8] = '{4'b1111, 4'b0000, TRANS_IDLE,   1'b1, RESP_OKAY, 4'b0010, 1, 0, 1'b0};

    reset = 1'b1;
    req = 4'b1010; lock = 4'b0; trans = TRANS_IDLE; ready = 1'b1; resp = RESP_OKAY;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.grant",     int'(grant),     1);
    chk("reset.addrOwner", int'(addrOwner), 0);
    chk("reset.dataOwner", int'(dataOwner), 0);
    chk("reset.locked",    int'(locked),    0);
    reset = 1'b0;

    // reset release then round-robin rotation
    foreach (tbl[i]) begin
      req = tbl[i].req; lock = tbl[i].lock; trans = tbl[i].trans;
      ready = tbl[i].ready; resp = tbl[i].resp;
      cycle("tbl");
      chk($sformatf("tbl%0d.grant", i),     int'(grant),     int'(tbl[i].g));
      chk($sformatf("tbl%0d.addrOwner", i), int'(addrOwner), tbl[i].a);
      chk($sformatf("tbl%0d.dataOwner", i), int'(dataOwner), tbl[i].d);
      chk($sformatf("tbl%0d.locked", i),    int'(locked),    int'(tbl[i].l));
    end

    // burst with wait states: owner 2 keeps the bus until IDLE
    drive(4'b0100, 4'b0, TRANS_IDLE,   1'b1, RESP_OKAY, "burst_grant");
    chk("burst.start", int'(grant), 4);
    drive(4'b0101, 4'b0, TRANS_NONSEQ, 1'b1, RESP_OKAY, "burst");
    drive(4'b0101, 4'b0, TRANS_SEQ,    1'b1, RESP_OKAY, "burst");
    drive(4'b0101, 4'b0, TRANS_SEQ,    1'b0, RESP_OKAY, "burst_wait");
    chk("burst.wait1", int'(grant), 4);
    drive(4'b0101, 4'b0, TRANS_SEQ,    1'b0, RESP_OKAY, "burst_wait");
    chk("burst.wait2", int'(grant), 4);
    drive(4'b0101, 4'b0, TRANS_SEQ,    1'b1, RESP_OKAY, "burst");
    drive(4'b0101, 4'b0, TRANS_SEQ,    1'b1, RESP_OKAY, "burst");
    chk("burst.seq_at_limit", int'(grant), 4);
    drive(4'b0101, 4'b0, TRANS_IDLE,   1'b1, RESP_OKAY, "burst_end");
    chk("burst.end", int'(grant), 1);

    // locked tenure of manager 3 ignores the hold limit
    drive(4'b1000, 4'b1000, TRANS_IDLE, 1'b1, RESP_OKAY, "lock_grant");
    chk("lock.grant",  int'(grant),  8);
    chk("lock.locked", int'(locked), 1);
    for (int i = 0; i < 6; i++) drive(4'b1001, 4'b1000, TRANS_NONSEQ, 1'b1, RESP_OKAY, "lock_xfer");
    chk("lock.after6", int'(grant), 8);
    drive(4'b1001, 4'b0000, TRANS_NONSEQ, 1'b1, RESP_OKAY, "lock_drop_busy");
    chk("lock.drop_nonseq", int'(grant), 8);
    drive(4'b1001, 4'b1000, TRANS_IDLE,   1'b1, RESP_OKAY, "lock_idle_held");
    chk("lock.idle_held", int'(grant), 8);
    drive(4'b1001, 4'b0000, TRANS_IDLE,   1'b1, RESP_OKAY, "lock_release");
    chk("lock.release",        int'(grant),  1);
    chk("lock.release_locked", int'(locked), 0);

    // hold limit of 2 transfers forces a handover on the 3rd NONSEQ
    drive(4'b0010, 4'b0, TRANS_IDLE,   1'b1, RESP_OKAY, "hold_grant");
    drive(4'b0110, 4'b0, TRANS_NONSEQ, 1'b1, RESP_OKAY, "hold");
    drive(4'b0110, 4'b0, TRANS_NONSEQ, 1'b1, RESP_OKAY, "hold");
    chk("hold.after2", int'(grant), 2);
    drive(4'b0110, 4'b0, TRANS_NONSEQ, 1'b1, RESP_OKAY, "hold_switch");
    chk("hold.switch", int'(grant), 4);

    // two-cycle ERROR response
    drive(4'b0100, 4'b0, TRANS_NONSEQ, 1'b1, RESP_OKAY,  "err_xfer");
    drive(4'b0101, 4'b0, TRANS_IDLE,   1'b0, RESP_ERROR, "err_first");
    chk("err.first", int'(grant), 4);
    drive(4'b0101, 4'b0, TRANS_IDLE,   1'b1, RESP_ERROR, "err_second");
    chk("err.second", int'(grant), 1);

    // asynchronous reset in the middle of a transfer
    drive(4'b0100, 4'b0100, TRANS_IDLE, 1'b1, RESP_OKAY, "pre_areset");
    trans = TRANS_NONSEQ;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("areset.grant",     int'(grant),     1);
    chk("areset.addrOwner", int'(addrOwner), 0);
    chk("areset.locked",    int'(locked),    0);
    @(posedge clk);
    #1 reset = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      req   = 4'($urandom_range(0, 15));
      lock  = 4'($urandom_range(0, 15));
      trans = 2'($urandom_range(0, 3));
      ready = ($urandom_range(0, 3) != 0);
      resp  = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
